// File: rtl/barrel_pkg.sv
// Shared width constant, stage-count derivation and per-stage payload type
// for the pipelined right barrel shifter.
package barrel_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;

  // One pipeline stage per shift-amount bit.
  function automatic int unsigned stage_count(input int unsigned width);
    return $clog2(width);
  endfunction

  localparam int unsigned DEFAULT_SHW = stage_count(DEFAULT_WIDTH);

  typedef struct packed {
    logic [DEFAULT_WIDTH-1:0] data;
    logic [DEFAULT_SHW-1:0]   shamt;
    logic                     arith;
    logic                     rot;
    logic                     fill;
  } barrel_payload_t;

endpackage

// File: rtl/barrel_shifter_right_pipe_if.sv
// Valid/ready input and output channels of the pipelined right barrel shifter.
// BARREL_ROTATE_EN adds the rot input carried with each beat.
interface barrel_shifter_right_pipe_if
  import barrel_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) ();

  localparam int unsigned SHW = stage_count(WIDTH);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] x;
  logic [SHW-1:0]   shamt;
  logic             arith;
`ifdef BARREL_ROTATE_EN
  logic             rot;
`endif
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out;

  modport master (
    output in_valid,
    output x,
    output shamt,
    output arith,
`ifdef BARREL_ROTATE_EN
    output rot,
`endif
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out
  );

  modport slave (
    input  in_valid,
    input  x,
    input  shamt,
    input  arith,
`ifdef BARREL_ROTATE_EN
    input  rot,
`endif
    input  out_ready,
    output in_ready,
    output out_valid,
    output out
  );

endinterface

// File: rtl/barrel_rshift_stage.sv
// One registered step of the right barrel shifter: shifts by STEP when its shamt bit is set.
// BARREL_ROTATE_EN adds a carried rot bit that turns the shift into a rotate.
module barrel_rshift_stage
  import barrel_pkg::*;
#(
  parameter  int unsigned WIDTH = DEFAULT_WIDTH,
  parameter  int unsigned STEP  = 1,
  localparam int unsigned SHW   = stage_count(WIDTH),
  localparam int unsigned BIT   = $clog2(STEP)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SHW-1:0]   in_shamt,
  input  logic             in_arith,
`ifdef BARREL_ROTATE_EN
  input  logic             in_rot,
`endif
  input  logic             in_fill,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [SHW-1:0]   out_shamt,
  output logic             out_arith,
`ifdef BARREL_ROTATE_EN
  output logic             out_rot,
`endif
  output logic             out_fill
);

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic [SHW-1:0]   shamt;
    logic             arith;
`ifdef BARREL_ROTATE_EN
    logic             rot;
`endif
    logic             fill;
  } payload_t;

  payload_t         payload_d, payload_q;
  logic             valid_d, valid_q;
  logic [WIDTH-1:0] shifted;

  // An empty slot, or one whose beat leaves this edge, can take a new beat.
  assign in_ready = ~valid_q | out_ready;

  always_comb begin
    shifted = in_data;
    if (in_shamt[BIT]) begin
`ifdef BARREL_ROTATE_EN
      if (in_rot) shifted = {in_data[STEP-1:0], in_data[WIDTH-1:STEP]};
      else        shifted = {{STEP{in_fill}}, in_data[WIDTH-1:STEP]};
`else
      shifted = {{STEP{in_fill}}, in_data[WIDTH-1:STEP]};
`endif
    end
  end

  always_comb begin
    valid_d   = valid_q;
    payload_d = payload_q;
    if (in_ready) valid_d = in_valid;
    if (in_valid && in_ready) begin
      payload_d.data  = shifted;
      payload_d.shamt = in_shamt;
      payload_d.arith = in_arith;
`ifdef BARREL_ROTATE_EN
      payload_d.rot   = in_rot;
`endif
      payload_d.fill  = in_fill;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q   <= 1'b0;
      payload_q <= '0;
    end else begin
      valid_q   <= valid_d;
      payload_q <= payload_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = payload_q.data;
  assign out_shamt = payload_q.shamt;
  assign out_arith = payload_q.arith;
`ifdef BARREL_ROTATE_EN
  assign out_rot   = payload_q.rot;
`endif
  assign out_fill  = payload_q.fill;

endmodule

// File: rtl/barrel_shifter_right_pipe.sv
// Pipelined right barrel shifter: one registered stage per shamt bit, valid/ready with full backpressure.
// BARREL_ROTATE_EN enables the rotate-right mode selected by bus.rot.
module barrel_shifter_right_pipe
  import barrel_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input logic                       clk,
  input logic                       reset,
  barrel_shifter_right_pipe_if.slave bus
);

  localparam int unsigned SHW = stage_count(WIDTH);

  // Chain index 0 is the input port, index SHW is the output port.
  logic             c_valid [SHW+1];
  logic             c_ready [SHW+1];
  logic [WIDTH-1:0] c_data  [SHW+1];
  logic [SHW-1:0]   c_shamt [SHW+1];
  logic             c_arith [SHW+1];
`ifdef BARREL_ROTATE_EN
  logic             c_rot   [SHW+1];
`endif
  logic             c_fill  [SHW+1];

  // The sign is captured once at entry so every stage fills with the original MSB.
  assign c_valid[0]   = bus.in_valid;
  assign bus.in_ready = c_ready[0];
  assign c_data[0]    = bus.x;
  assign c_shamt[0]   = bus.shamt;
  assign c_arith[0]   = bus.arith;
`ifdef BARREL_ROTATE_EN
  assign c_rot[0]     = bus.rot;
`endif
  assign c_fill[0]    = bus.arith & bus.x[WIDTH-1];

  for (genvar g = 0; g < SHW; g++) begin : g_stage
    barrel_rshift_stage #(
      .WIDTH (WIDTH),
      .STEP  (1 << (SHW - 1 - g))
    ) u_stage (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (c_valid[g]),
      .in_ready  (c_ready[g]),
      .in_data   (c_data[g]),
      .in_shamt  (c_shamt[g]),
      .in_arith  (c_arith[g]),
`ifdef BARREL_ROTATE_EN
      .in_rot    (c_rot[g]),
`endif
      .in_fill   (c_fill[g]),
      .out_valid (c_valid[g+1]),
      .out_ready (c_ready[g+1]),
      .out_data  (c_data[g+1]),
      .out_shamt (c_shamt[g+1]),
      .out_arith (c_arith[g+1]),
`ifdef BARREL_ROTATE_EN
      .out_rot   (c_rot[g+1]),
`endif
      .out_fill  (c_fill[g+1])
    );
  end

  assign bus.out_valid = c_valid[SHW];
  assign c_ready[SHW]  = bus.out_ready;
  assign bus.out       = c_data[SHW];

  // Side-band fields have no consumer past the last stage.
  logic unused_tail;
`ifdef BARREL_ROTATE_EN
  assign unused_tail = ^{c_shamt[SHW], c_arith[SHW], c_fill[SHW], c_rot[SHW]};
`else
  assign unused_tail = ^{c_shamt[SHW], c_arith[SHW], c_fill[SHW]};
`endif

endmodule

// File: tb/tb_barrel_shifter_right_pipe.sv
// Randomized and directed bench for barrel_shifter_right_pipe against an arithmetic reference model.
module tb_barrel_shifter_right_pipe;
  import barrel_pkg::*;

  localparam int unsigned W = DEFAULT_WIDTH;

  logic clk;
  logic reset;
  logic drv_rot;

  barrel_shifter_right_pipe_if #(.WIDTH(W)) bus ();

  barrel_shifter_right_pipe #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

`ifdef BARREL_ROTATE_EN
  assign bus.rot = drv_rot;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned     vectors;
  int unsigned     miscompares;
  int unsigned     out_count;
  barrel_payload_t pend_q[$];
  logic            held_v;
  logic [W-1:0]    held_d;

  function automatic logic [W-1:0] ref_shift(input barrel_payload_t b);
    int unsigned      s;
    logic [2*W-1:0]   w;
    logic signed [W-1:0] sx;
    s = int'(b.shamt);
    if (b.rot) begin
      w = {b.data, b.data} >> s;
      return w[W-1:0];
    end else if (b.arith) begin
      sx = b.data;
      return sx >>> s;
    end
    return b.data >> s;
  endfunction

  task automatic set_beat(input logic [W-1:0] x, input logic [2:0] sh, input logic ar, input logic rt);
    bus.in_valid = 1'b1;
    bus.x        = x;
    bus.shamt    = sh;
    bus.arith    = ar;
    drv_rot      = rt;
  endtask

  // One clock: settle, check output beat against model, record input beat, advance to next negedge.
  task automatic cycle();
    barrel_payload_t b;
    logic [W-1:0]    e;
    #1;
    if (held_v) begin
      vectors++;
      if (bus.out_valid !== 1'b1 || bus.out !== held_d) begin
        miscompares++;
        $display("FAIL hold_stable: out_valid=%b out=%h, required 1 %h", bus.out_valid, bus.out, held_d);
      end
    end
    if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
      vectors++;
      out_count++;
      if (pend_q.size() == 0) begin
        miscompares++;
        $display("FAIL spurious_out: out=%h, required no beat", bus.out);
      end else begin
        b = pend_q.pop_front();
        e = ref_shift(b);
        if (bus.out !== e) begin
          miscompares++;
          $display("FAIL data_out: x=%h sh=%0d ar=%b rot=%b out=%h, required %h",
                   b.data, b.shamt, b.arith, b.rot, bus.out, e);
        end
      end
    end
    if (bus.in_valid === 1'b1 && bus.in_ready === 1'b1) begin
      b.data  = bus.x;
      b.shamt = bus.shamt;
      b.arith = bus.arith;
      b.rot   = drv_rot;
      b.fill  = bus.arith & bus.x[W-1];
      pend_q.push_back(b);
    end
    held_v = bus.out_valid && !bus.out_ready && !reset;
    held_d = bus.out;
    if (reset) pend_q.delete();
    @(negedge clk);
  endtask

  task automatic drain();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 20 && pend_q.size() > 0; i++) cycle();
    vectors++;
    if (pend_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d beats left, required 0", pend_q.size());
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.x = '0; bus.shamt = '0; bus.arith = 1'b0; drv_rot = 1'b0;
    @(negedge clk);
    cycle();
    cycle();
    reset = 1'b0;
    #1;
    vectors += 3;
    if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid: %b, required 0", bus.out_valid); end
    if (bus.out !== '0) begin miscompares++; $display("FAIL reset_out: %h, required 00", bus.out); end
    if (bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready: %b, required 1", bus.in_ready); end
  endtask

  task automatic test_directed();
    logic [W-1:0] dx   [5] = '{8'hB2, 8'hB2, 8'h80, 8'h80, 8'h5C};
    logic [2:0]   dsh  [5] = '{3'd3, 3'd3, 3'd7, 3'd7, 3'd0};
    logic         dar  [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    logic [W-1:0] dexp [5] = '{8'h16, 8'hF6, 8'hFF, 8'h01, 8'h5C};
    for (int unsigned i = 0; i < 5; i++) begin
      bus.out_ready = 1'b1;
      set_beat(dx[i], dsh[i], dar[i], 1'b0);
      cycle();
      bus.in_valid = 1'b0;
      for (int unsigned k = 1; k <= 3; k++) begin
        #1;
        vectors++;
        if (bus.out_valid !== (k == 3)) begin
          miscompares++;
          $display("FAIL latency[%0d] cyc%0d: out_valid=%b, required %b", i, k, bus.out_valid, (k == 3));
        end
        if (k == 3) begin
          vectors++;
          if (bus.out !== dexp[i]) begin
            miscompares++;
            $display("FAIL directed[%0d]: out=%h, required %h", i, bus.out, dexp[i]);
          end
        end
        cycle();
      end
    end
  endtask

  task automatic test_stream();
    logic [W-1:0] a5;
    a5 = 8'hA5;
    bus.out_ready = 1'b1;
    for (int unsigned c = 0; c < 12; c++) begin
      if (c < 8) set_beat(a5, 3'(c), 1'b0, 1'b0);
      else bus.in_valid = 1'b0;
      #1;
      if (c < 8) begin
        vectors++;
        if (bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL stream_in_ready c%0d: %b, required 1", c, bus.in_ready); end
      end
      if (c >= 3 && c < 11) begin
        vectors++;
        if (bus.out_valid !== 1'b1 || bus.out !== (a5 >> (c - 3))) begin
          miscompares++;
          $display("FAIL stream c%0d: valid=%b out=%h, required 1 %h", c, bus.out_valid, bus.out, a5 >> (c - 3));
        end
      end
      cycle();
    end
  endtask

  task automatic test_backpressure();
    barrel_payload_t beats [5];
    int unsigned idx, start_cnt;
    logic fire;
    for (int unsigned i = 0; i < 5; i++) begin
      beats[i].data  = 8'($urandom);
      beats[i].shamt = 3'($urandom);
      beats[i].arith = 1'($urandom);
    end
    idx = 0;
    start_cnt = out_count;
    bus.out_ready = 1'b0;
    for (int unsigned c = 0; c < 6; c++) begin
      set_beat(beats[idx].data, beats[idx].shamt, beats[idx].arith, 1'b0);
      #1;
      fire = bus.in_ready;
      cycle();
      if (fire) idx++;
    end
    #1;
    vectors += 2;
    if (idx != 3) begin miscompares++; $display("FAIL bp_accepted: %0d, required 3", idx); end
    if (bus.in_ready !== 1'b0) begin miscompares++; $display("FAIL bp_in_ready: %b, required 0", bus.in_ready); end
    bus.out_ready = 1'b1;
    for (int unsigned c = 0; c < 30 && (idx < 5 || pend_q.size() > 0); c++) begin
      if (idx < 5) set_beat(beats[idx].data, beats[idx].shamt, beats[idx].arith, 1'b0);
      else bus.in_valid = 1'b0;
      #1;
      fire = bus.in_valid && bus.in_ready;
      cycle();
      if (fire) idx++;
    end
    bus.in_valid = 1'b0;
    vectors++;
    if (out_count - start_cnt != 5 || pend_q.size() != 0) begin
      miscompares++;
      $display("FAIL bp_count: %0d results, %0d pending, required 5 and 0", out_count - start_cnt, pend_q.size());
    end
  endtask

  task automatic test_push_pop_full();
    bus.out_ready = 1'b0;
    for (int unsigned c = 0; c < 3; c++) begin
      set_beat(8'($urandom), 3'($urandom), 1'($urandom), 1'b0);
      cycle();
    end
    bus.in_valid = 1'b0;
    cycle();
    set_beat(8'hC3, 3'd2, 1'b1, 1'b0);
    bus.out_ready = 1'b1;
    #1;
    vectors += 2;
    if (bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL full_push_ready: %b, required 1", bus.in_ready); end
    if (bus.out_valid !== 1'b1) begin miscompares++; $display("FAIL full_pop_valid: %b, required 1", bus.out_valid); end
    cycle();
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    #1;
    vectors++;
    if (pend_q.size() != 3 || bus.out_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL full_occupancy: pending=%0d valid=%b, required 3 1", pend_q.size(), bus.out_valid);
    end
    cycle();
    drain();
  endtask

  task automatic test_reset_midstream();
    bus.out_ready = 1'b1;
    set_beat(8'hF0, 3'd1, 1'b1, 1'b0);
    cycle();
    set_beat(8'h0F, 3'd2, 1'b0, 1'b0);
    cycle();
    bus.in_valid = 1'b0;
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    #1;
    vectors += 3;
    if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL midrst_valid: %b, required 0", bus.out_valid); end
    if (bus.out !== '0) begin miscompares++; $display("FAIL midrst_out: %h, required 00", bus.out); end
    if (bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL midrst_in_ready: %b, required 1", bus.in_ready); end
    for (int unsigned c = 0; c < 6; c++) begin
      #1;
      vectors++;
      if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL midrst_stale c%0d: valid=%b, required 0", c, bus.out_valid); end
      cycle();
    end
  endtask

`ifdef BARREL_ROTATE_EN
  task automatic test_rotate();
    bus.out_ready = 1'b1;
    set_beat(8'hB2, 3'd3, 1'b1, 1'b1);
    cycle();
    bus.in_valid = 1'b0;
    cycle();
    cycle();
    #1;
    vectors++;
    if (bus.out_valid !== 1'b1 || bus.out !== 8'h56) begin
      miscompares++;
      $display("FAIL rotate: valid=%b out=%h, required 1 56", bus.out_valid, bus.out);
    end
    cycle();
  endtask
`endif

  task automatic test_random();
    for (int unsigned c = 0; c < 400; c++) begin
      bus.in_valid = ($urandom_range(0, 3) != 0);
      bus.x        = 8'($urandom);
      bus.shamt    = 3'($urandom);
      bus.arith    = 1'($urandom);
`ifdef BARREL_ROTATE_EN
      drv_rot      = 1'($urandom);
`else
      drv_rot      = 1'b0;
`endif
      bus.out_ready = ($urandom_range(0, 9) < 7);
      cycle();
    end
    drain();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vectors = 0;
    miscompares = 0;
    out_count = 0;
    held_v = 1'b0;
    held_d = '0;
    test_reset();
    test_directed();
    test_stream();
    test_backpressure();
    test_push_pop_full();
    test_reset_midstream();
`ifdef BARREL_ROTATE_EN
    test_rotate();
`endif
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/barrel_shifter_right_pipe.md
Name: barrel_shifter_right_pipe

Overview:
Pipelined right barrel shifter: the opposite-direction companion to the team's combinational left barrel shifter (8-bit data, 3-bit shift amount).
- Splits the shift into log2(WIDTH) registered stages: shift by 4, then 2, then 1 for WIDTH=8.
- Uses valid/ready handshakes on input and output, with full backpressure.
- Sits on the datapath wherever a right shift must close timing at one result per cycle.

Parameters:
WIDTH, 8, data width; must be a power of two >= 2
SHW, $clog2(WIDTH), shift-amount width and number of pipeline stages (derived; do not override)

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
in_valid  input  1  input beat present
in_ready  output  1  block can accept input this cycle
x  input  WIDTH  data to shift
shamt  input  SHW  right shift amount, 0..WIDTH-1
arith  input  1  1 = arithmetic (sign fill), 0 = logical (zero fill)
out_valid  output  1  result present
out_ready  input  1  consumer accepts result this cycle
out  output  WIDTH  shifted result

Behaviour:
- Reset: synchronous, active-high (reset=1 sampled on the clk rising edge).
  - All stage valid bits go to 0 and all data registers go to 0.
  - out_valid=0 and out=0.
  - in_ready=1 in the first cycle after reset is released.
- Handshake:
  - A transfer occurs when valid & ready are both 1 on a clk edge.
  - in_valid may not depend on in_ready.
  - out/out_valid are held stable while out_valid=1 and out_ready=0.
- Pipeline:
  - Stage k (k = SHW-1 down to 0) registers data, remaining shamt bits, arith and a valid bit.
  - Stage k shifts right by 2^k when shamt[k]=1.
  - Fill bit: arith ? data[WIDTH-1] of the original input : 0. The sign is carried with the beat, not re-sampled.
- Latency and throughput:
  - Latency is exactly SHW cycles from input handshake to out_valid when unstalled (3 for WIDTH=8).
  - Throughput is 1 beat per cycle.
- Stall rule:
  - Stage i advances when its successor is empty or the successor advances.
  - The last stage advances on out_ready.
  - in_ready = ~v_first | advance_first, so a pipeline bubble absorbs a stall.
  - No combinational path from in_valid to out_valid. A combinational path out_ready -> in_ready is permitted.
- Boundary conditions:
  - shamt=0: passes data through unchanged.
  - shamt=WIDTH-1 with arith=1 and negative x: result is all ones.
  - Full pipeline with out_ready=0: in_ready=0 and no data is lost or duplicated.
  - Simultaneous push and pop when full: both occur in the same cycle.
  - reset asserted mid-stream: all in-flight beats are discarded; no beat appears after reset.
- Ordering: results leave in input order.

Optional Feature:
- Macro: BARREL_ROTATE_EN.
- When defined:
  - Adds input port rot (1 bit), carried with the beat.
  - rot=1 rotates right (bits shifted out re-enter at the MSB) and overrides arith.
- When undefined:
  - No rot port and no rotate logic.
  - Behaviour is exactly as described above.

Decomposition:
- Shared package barrel_pkg holds:
  - the default width constant (8);
  - the stage count derivation;
  - a typedef for the per-stage payload struct {data, shamt, arith, rot, fill}.
- One sub-module, barrel_rshift_stage:
  - parameters WIDTH and STEP;
  - registered payload plus valid with local ready/advance logic;
  - instantiated SHW times by a generate loop.

Test Plan:
- Logical shift: x=8'b1011_0010, shamt=3, arith=0, out_ready=1 -> out=8'b0001_0110 exactly 3 cycles after handshake.
- Arithmetic shift: same x, shamt=3, arith=1 -> out=8'b1111_0110. x=8'h80, shamt=7, arith=1 -> 8'hFF. x=8'h80, shamt=7, arith=0 -> 8'h01.
- Streaming: 8 back-to-back beats (all shamt 0..7 on x=8'hA5, logical), out_ready=1 -> 8 consecutive out_valid cycles, in order, no bubbles; shamt=0 gives 8'hA5 and shamt=7 gives 8'h01.
- Backpressure:
  - Hold out_ready=0 for 6 cycles while driving 5 beats: in_ready drops after 3 accepted beats and out holds stable.
  - Release: all 5 results arrive in order with none lost or duplicated.
- Reset mid-stream: assert reset for 1 cycle with 2 beats in flight -> out_valid=0 and out=0 next cycle, no stale result ever appears, in_ready=1.
- With BARREL_ROTATE_EN: x=8'b1011_0010, shamt=3, rot=1, arith=1 -> out=8'b0101_0110.
